// File: rtl/global_reg_loader.sv
// Assembles NUM_REGS x REG_BYTES registers from a byte stream into shadow storage and commits them atomically.
// Optional build macro: GREG_CHECKSUM_EN adds a trailing mod-256 checksum byte and a CHECK state.
module global_reg_loader #(
   parameter int unsigned NUM_REGS  = 4,
   parameter int unsigned REG_BYTES = 1,
   parameter int unsigned BC_W      = 6
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic                              START,
   input  logic                              ABORT,
   input  logic                              RVALID,
   input  logic [7:0]                        RBYTE,
   output logic                              RREADY,
   output logic [NUM_REGS*REG_BYTES*8-1:0]   REGS,
   output logic [BC_W-1:0]                   BC,
   output logic                              BUSY,
   output logic                              FINISH,
   output logic                              ERROR
);

   localparam int unsigned TOTAL = NUM_REGS * REG_BYTES;
   localparam int unsigned RW    = TOTAL * 8;
`ifdef GREG_CHECKSUM_EN
   localparam int unsigned FRAME = TOTAL + 1;
   localparam logic [BC_W-1:0] TOTAL_BC = BC_W'(TOTAL);
`else
   localparam int unsigned FRAME = TOTAL;
`endif
   localparam logic [BC_W-1:0] LAST_BC  = BC_W'(FRAME - 1);
   localparam logic [BC_W-1:0] FRAME_BC = BC_W'(FRAME);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
`ifdef GREG_CHECKSUM_EN
   localparam logic [1:0] S_CHECK  = 2'd2;
`endif
   localparam logic [1:0] S_COMMIT = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [BC_W-1:0] bc_q, bc_d;
   logic [RW-1:0]   shadow_q, shadow_d;
   logic [RW-1:0]   regs_q, regs_d;
   logic            busy_q, busy_d;
   logic            finish_q, finish_d;
`ifdef GREG_CHECKSUM_EN
   logic [7:0]      sum_q, sum_d;
   logic [7:0]      cks_q, cks_d;
   logic            error_q, error_d;
`endif

   always_comb begin
      state_d  = state_q;
      bc_d     = bc_q;
      shadow_d = shadow_q;
      regs_d   = regs_q;
      finish_d = 1'b0;
`ifdef GREG_CHECKSUM_EN
      sum_d    = sum_q;
      cks_d    = cks_q;
      error_d  = error_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (START && !ABORT) begin
               state_d = S_LOAD;
               bc_d    = '0;
`ifdef GREG_CHECKSUM_EN
               error_d = 1'b0;
               sum_d   = '0;
`endif
            end
         end
         S_LOAD: begin
            if (ABORT) begin
               state_d = S_IDLE;
            end else if (RVALID) begin
               // Shadow byte index equals BC: reg k lane j sits at flat byte k*REG_BYTES+j.
               for (int unsigned i = 0; i < TOTAL; i++) begin
                  if (bc_q == BC_W'(i)) shadow_d[i*8 +: 8] = RBYTE;
               end
`ifdef GREG_CHECKSUM_EN
               if (bc_q < TOTAL_BC) sum_d = sum_q + RBYTE;
               else                 cks_d = RBYTE;
`endif
               if (bc_q != FRAME_BC) bc_d = bc_q + 1'b1;
`ifdef GREG_CHECKSUM_EN
               if (bc_q == LAST_BC) state_d = S_CHECK;
`else
               if (bc_q == LAST_BC) state_d = S_COMMIT;
`endif
            end
         end
`ifdef GREG_CHECKSUM_EN
         S_CHECK: begin
            if (ABORT) begin
               state_d = S_IDLE;
            end else if (sum_q == cks_q) begin
               state_d = S_COMMIT;
            end else begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end
         end
`endif
         S_COMMIT: begin
            state_d = S_IDLE;
            if (!ABORT) begin
               regs_d   = shadow_q;
               finish_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q  <= S_IDLE;
         bc_q     <= '0;
         shadow_q <= '0;
         regs_q   <= '0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
`ifdef GREG_CHECKSUM_EN
         sum_q    <= '0;
         cks_q    <= '0;
         error_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         bc_q     <= bc_d;
         shadow_q <= shadow_d;
         regs_q   <= regs_d;
         busy_q   <= busy_d;
         finish_q <= finish_d;
`ifdef GREG_CHECKSUM_EN
         sum_q    <= sum_d;
         cks_q    <= cks_d;
         error_q  <= error_d;
`endif
      end
   end

   assign RREADY = (state_q == S_LOAD);
   assign REGS   = regs_q;
   assign BC     = bc_q;
   assign BUSY   = busy_q;
   assign FINISH = finish_q;
`ifdef GREG_CHECKSUM_EN
   assign ERROR  = error_q;
`else
   assign ERROR  = 1'b0;
`endif

endmodule

// File: tb/tb_global_reg_loader.sv
// Scoreboard bench for global_reg_loader (2 regs x 2 bytes); honours GREG_CHECKSUM_EN when defined.
module tb_global_reg_loader;
   localparam int unsigned NR  = 2;
   localparam int unsigned RB  = 2;
   localparam int unsigned BCW = 6;
   localparam int TOTAL = 4;
`ifdef GREG_CHECKSUM_EN
   localparam int CKS = 1;
`else
   localparam int CKS = 0;
`endif
   localparam int FRAME = TOTAL + CKS;

   logic            ACLK = 1'b0;
   logic            ARESET, START, ABORT, RVALID;
   logic [7:0]      RBYTE;
   logic            RREADY, BUSY, FINISH, ERROR;
   logic [31:0]     REGS;
   logic [BCW-1:0]  BC;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_regs = '0;
   logic [31:0] exp_q[$];
   bit          mon_en = 1'b0;

   always #5 ACLK = ~ACLK;

   global_reg_loader #(.NUM_REGS(NR), .REG_BYTES(RB), .BC_W(BCW)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .START(START), .ABORT(ABORT),
      .RVALID(RVALID), .RBYTE(RBYTE), .RREADY(RREADY), .REGS(REGS),
      .BC(BC), .BUSY(BUSY), .FINISH(FINISH), .ERROR(ERROR)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge ACLK);
      #1;
   endtask

   function automatic logic [7:0] sum4(input logic [7:0] a, b, c, d);
      return a + b + c + d;
   endfunction

   // Monitor: every FINISH pulse must match the oldest expected commit.
   always @(negedge ACLK) begin
      if (mon_en && FINISH === 1'b1) begin
         chk("sb_pending", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) chk("sb_regs", REGS, exp_q.pop_front());
      end
   end

   task automatic run_frame(input logic [7:0] b0, b1, b2, b3, input int gap,
                            input int abort_at, input logic [7:0] cks);
      logic [7:0]  fb [5];
      logic [31:0] expv;
      bit          commit;
      int          g;
      fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = cks;
      expv   = {b3, b2, b1, b0};
      commit = (abort_at < 0) && (CKS == 0 || cks == sum4(b0, b1, b2, b3));
      if (commit) exp_q.push_back(expv);
      START = 1'b1;
      tick;
      START = 1'b0;
      chk("err_clr", ERROR, 1'b0);
      chk("busy_load", BUSY, 1'b1);
      chk("bc_start", BC, 0);
      for (int i = 0; i < FRAME; i++) begin
         if (i == abort_at) begin
            ABORT = 1'b1; RVALID = 1'b1; RBYTE = 8'($urandom);
            tick;
            ABORT = 1'b0; RVALID = 1'b0;
            chk("abort_bc", BC, i);
            chk("abort_busy", BUSY, 1'b0);
            chk("abort_rready", RREADY, 1'b0);
            chk("abort_regs", REGS, model_regs);
            chk("abort_err", ERROR, 1'b0);
            return;
         end
         chk("rready_load", RREADY, 1'b1);
         RVALID = 1'b1; RBYTE = fb[i];
         tick;
         RVALID = 1'b0;
         chk("bc_inc", BC, i + 1);
         if (i < FRAME - 1) begin
            g = (gap == 2) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
               RBYTE = 8'($urandom); START = 1'($urandom);
               tick;
               START = 1'b0;
               chk("bc_gap", BC, i + 1);
            end
         end
      end
      chk("rready_drop", RREADY, 1'b0);
      RVALID = 1'b1; RBYTE = 8'($urandom);
      repeat (CKS + 1) tick;
      if (commit) model_regs = expv;
      chk("finish", FINISH, commit);
      chk("error", ERROR, (CKS != 0) && !commit);
      chk("bc_final", BC, FRAME);
      chk("regs_final", REGS, model_regs);
      chk("busy_done", BUSY, 1'b0);
      RVALID = 1'b0;
      tick;
      chk("finish_1cyc", FINISH, 1'b0);
      chk("bc_hold", BC, FRAME);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r0, r1, r2, r3, ck;
      int ab;
      ARESET = 1'b1; START = 1'b0; ABORT = 1'b0; RVALID = 1'b0; RBYTE = '0;
      repeat (3) tick;
      chk("rst_regs", REGS, 0);
      chk("rst_bc", BC, 0);
      chk("rst_rready", RREADY, 1'b0);
      chk("rst_finish", FINISH, 1'b0);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_error", ERROR, 1'b0);
      ARESET = 1'b0;
      mon_en = 1'b1;
      // RVALID without START is ignored
      RVALID = 1'b1; RBYTE = 8'h5A;
      repeat (2) tick;
      RVALID = 1'b0;
      chk("idle_bc", BC, 0);
      chk("idle_rready", RREADY, 1'b0);

      run_frame(8'h05, 8'h10, 8'h2A, 8'h03, 0, -1, sum4(8'h05, 8'h10, 8'h2A, 8'h03));
      chk("basic_regs", REGS, 32'h032A1005);

      run_frame(8'h34, 8'h12, 8'h78, 8'h56, 0, -1, sum4(8'h34, 8'h12, 8'h78, 8'h56));
      chk("wide_reg0", REGS[15:0], 16'h1234);
      chk("wide_reg1", REGS[31:16], 16'h5678);
      run_frame(8'h34, 8'h12, 8'h78, 8'h56, 1, -1, sum4(8'h34, 8'h12, 8'h78, 8'h56));
      chk("gap_reg0", REGS[15:0], 16'h1234);
      chk("gap_reg1", REGS[31:16], 16'h5678);

      run_frame(8'h05, 8'h10, 8'h2A, 8'h03, 0, -1, sum4(8'h05, 8'h10, 8'h2A, 8'h03));
      run_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 2, 8'h00);
      chk("abort_keep", REGS, 32'h032A1005);
      run_frame(8'h11, 8'h22, 8'h33, 8'h44, 0, -1, sum4(8'h11, 8'h22, 8'h33, 8'h44));
      chk("after_abort", REGS, 32'h44332211);

`ifdef GREG_CHECKSUM_EN
      run_frame(8'h01, 8'h02, 8'h03, 8'h04, 0, -1, 8'h0A);
      chk("cks_ok_regs", REGS, 32'h04030201);
      run_frame(8'hF1, 8'hF2, 8'hF3, 8'hF4, 0, -1, 8'h0B);
      chk("cks_bad_regs", REGS, 32'h04030201);
      chk("cks_bad_err", ERROR, 1'b1);
`endif

      for (int n = 0; n < 40; n++) begin
         r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
         ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1;
         ck = sum4(r0, r1, r2, r3);
         if ($urandom_range(0, 2) == 0) ck = ck + 8'd1;
         run_frame(r0, r1, r2, r3, 2, ab, ck);
      end

      // Reset mid-frame
      START = 1'b1;
      tick;
      START = 1'b0;
      for (int i = 0; i < 3; i++) begin
         RVALID = 1'b1; RBYTE = 8'($urandom);
         tick;
      end
      ARESET = 1'b1; RVALID = 1'b1;
      tick;
      model_regs = '0;
      chk("mid_rst_regs", REGS, model_regs);
      chk("mid_rst_bc", BC, 0);
      chk("mid_rst_rready", RREADY, 1'b0);
      chk("mid_rst_busy", BUSY, 1'b0);
      chk("mid_rst_error", ERROR, 1'b0);
      ARESET = 1'b0;
      repeat (3) tick;
      chk("post_rst_rready", RREADY, 1'b0);
      chk("post_rst_bc", BC, 0);
      chk("post_rst_regs", REGS, model_regs);
      RVALID = 1'b0;

      repeat (3) tick;
      chk("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
